// File: rtl/wb_arbiter_2x1.sv
// Two-master, one-slave round-robin arbiter for the pipelined Wishbone bus.
// A master owns the slave port for a whole CYC; requests to the slave are
// capped at MAX_OUTSTANDING accepted-but-unacknowledged transfers.
module wb_arbiter_2x1 #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                    CLK,
    input  logic                    RST,

    input  logic                    m0_CYC_I,
    input  logic                    m0_STB_I,
    input  logic                    m0_WE_I,
    input  logic [ADDR_WIDTH-1:0]   m0_ADR_I,
    input  logic [DATA_WIDTH/8-1:0] m0_SEL_I,
    input  logic [DATA_WIDTH-1:0]   m0_DAT_I,
    output logic                    m0_STALL_O,
    output logic                    m0_ACK_O,
    output logic [DATA_WIDTH-1:0]   m0_DAT_O,

    input  logic                    m1_CYC_I,
    input  logic                    m1_STB_I,
    input  logic                    m1_WE_I,
    input  logic [ADDR_WIDTH-1:0]   m1_ADR_I,
    input  logic [DATA_WIDTH/8-1:0] m1_SEL_I,
    input  logic [DATA_WIDTH-1:0]   m1_DAT_I,
    output logic                    m1_STALL_O,
    output logic                    m1_ACK_O,
    output logic [DATA_WIDTH-1:0]   m1_DAT_O,

    output logic                    s_CYC_O,
    output logic                    s_STB_O,
    output logic                    s_WE_O,
    output logic [ADDR_WIDTH-1:0]   s_ADR_O,
    output logic [DATA_WIDTH/8-1:0] s_SEL_O,
    output logic [DATA_WIDTH-1:0]   s_DAT_O,
    input  logic                    s_STALL_I,
    input  logic                    s_ACK_I,
    input  logic [DATA_WIDTH-1:0]   s_DAT_I,

    output logic [1:0]              grant_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t          state;
    logic            last_owner;
    logic [CW-1:0]   outstanding;

    logic            own0;
    logic            own1;
    logic            o_cyc;
    logic            o_stb;
    logic            full;
    logic            accept;
    logic            ack_ok;

    // Owner-side mux and slave-side pass-through, gated by the current owner
    always_comb begin
        own0   = (state == OWN0);
        own1   = (state == OWN1);
        full   = (outstanding == CW'(MAX_OUTSTANDING));

        o_cyc  = (own0 & m0_CYC_I) | (own1 & m1_CYC_I);
        o_stb  = (own0 & m0_STB_I) | (own1 & m1_STB_I);

        s_CYC_O = o_cyc;
        s_STB_O = o_cyc & o_stb & ~full;
        s_WE_O  = 1'b0;
        s_ADR_O = '0;
        s_SEL_O = '0;
        s_DAT_O = '0;
        if (own0) begin
            s_WE_O  = m0_WE_I;
            s_ADR_O = m0_ADR_I;
            s_SEL_O = m0_SEL_I;
            s_DAT_O = m0_DAT_I;
        end else if (own1) begin
            s_WE_O  = m1_WE_I;
            s_ADR_O = m1_ADR_I;
            s_SEL_O = m1_SEL_I;
            s_DAT_O = m1_DAT_I;
        end

        accept = s_STB_O & ~s_STALL_I;
        // An ACK with nothing outstanding belongs to an abandoned cycle
        ack_ok = s_ACK_I & o_cyc & (outstanding != '0);

        m0_STALL_O = own0 ? (s_STALL_I | full) : 1'b1;
        m0_ACK_O   = own0 & ack_ok;
        m0_DAT_O   = own0 ? s_DAT_I : '0;
        m1_STALL_O = own1 ? (s_STALL_I | full) : 1'b1;
        m1_ACK_O   = own1 & ack_ok;
        m1_DAT_O   = own1 ? s_DAT_I : '0;

        grant_o = {own1, own0};
    end

    // Ownership FSM, round-robin memory and outstanding-request counter
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            last_owner  <= 1'b1;
            outstanding <= '0;
        end else begin
            case (state)
                IDLE: begin
                    outstanding <= '0;
                    if (m0_CYC_I && m1_CYC_I)
                        state <= last_owner ? OWN0 : OWN1;
                    else if (m0_CYC_I)
                        state <= OWN0;
                    else if (m1_CYC_I)
                        state <= OWN1;
                end
                OWN0, OWN1: begin
                    if (o_cyc) begin
                        if (accept && !ack_ok)
                            outstanding <= outstanding + CW'(1);
                        else if (!accept && ack_ok)
                            outstanding <= outstanding - CW'(1);
                    end else begin
                        outstanding <= '0;
                        last_owner  <= own1;
                        if (own0)
                            state <= m1_CYC_I ? OWN1 : IDLE;
                        else
                            state <= m0_CYC_I ? OWN0 : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
